exe_mem_stage: RTL
==================

# exe_mem_stage

Parametrised EX→MEM pipeline stage register with valid/ready handshake, a 2-entry skid buffer for back-pressure, and synchronous flush. Sits between the execute stage and the data-memory stage of the MIPS pipeline. It replaces free-running stage registers with a stage that can stall without combinational ready paths, and it kills in-flight instructions on branch resolution. Control and data payloads are carried separately, so bubbles and flushes zero only the control field.

## Interface
Parameters:
- CTRL_W, 7: control payload width (MemWrite, MemRead, MemtoReg, RegWrite, Zero, Branch[1:0]).
- DATA_W, 69: data payload width (ALUresult 32, ReadData2 32, WriteRegister 5).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  EX presents an instruction.
- in_ready  out  1  stage can accept; driven from registered state only.
- in_ctrl  in  CTRL_W  EX control payload.
- in_data  in  DATA_W  EX data payload.
- flush  in  1  kill all held entries and any same-cycle input.
- out_valid  out  1  MEM-side instruction present.
- out_ready  in  1  MEM consumes the instruction.
- out_ctrl  out  CTRL_W  control payload; all-zero whenever out_valid=0.
- out_data  out  DATA_W  data payload; don't-care when out_valid=0.
- occupancy  out  2  number of held entries, 0..2.

## Operation
- Storage: main register (drives outputs) and skid register. States EMPTY (0 entries), ONE (main), FULL (main+skid).
- Handshakes: accept = in_valid & in_ready; take = out_valid & out_ready.
- in_ready = (state != FULL). It depends on no input.
- State transitions:
  - EMPTY: accept → ONE, main ← in.
  - ONE: accept & take → ONE, main ← in. accept & !take → FULL, skid ← in. !accept & take → EMPTY. Otherwise hold.
  - FULL: take → ONE, main ← skid. Otherwise hold. No accept is possible in FULL.
- Ordering: strictly FIFO; no reorder, drop or duplicate except on flush or reset.
- Flush has priority over every transition. Next state is EMPTY, both registers' ctrl fields are zeroed, and same-cycle input is discarded even if in_valid=1. A take in the flush cycle still counts as consumed by MEM.
- Bubble: out_ctrl is forced to 0 when out_valid=0, so MEM never sees a stray RegWrite or MemWrite.
- Data fields need no clearing on flush or reset.

## Timing
- Reset values: state=EMPTY, out_valid=0, out_ctrl=0, in_ready=1 (registered reset value), occupancy=0. out_data is unspecified. Reset mid-operation discards both entries in the same edge.
- Latency: an instruction accepted at edge N appears on outputs after edge N, with out_valid=1 in cycle N+1.
- Throughput: 1 per cycle while out_ready=1.
- in_ready deasserts the cycle after FULL is entered and reasserts the cycle after the first take in FULL.
- A stalled output (out_valid=1, out_ready=0) holds out_ctrl and out_data stable until taken or flushed.
- Flush takes effect at the next edge. The following cycle shows out_valid=0 and in_ready=1.
- Simultaneous reset and flush: reset result (identical).

## Structure
- Shared package pipe_pkg: control-field bit positions, the ctrl/data widths as constants (CTRL_W=7, DATA_W=69), and the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2).
- One natural sub-module, skid_reg2, is the generic 2-entry skid buffer (state machine plus registers). exe_mem_stage wraps it with payload concatenation, bubble zeroing and flush routing. The same skid_reg2 is reused for the IF/ID, ID/EX and MEM/WB successors.

## Test plan
- Reset release, out_ready=1, feed in_ctrl=7'h5A, in_data=69'h1234 for one cycle → out_valid=1 with the same values exactly one cycle later; occupancy 0→1→0.
- Hold out_ready=0 and feed 3 back-to-back instructions A, B, C → A, B accepted; in_ready=0 from the cycle after B; C held at input. Release out_ready → outputs A, B, C in order, no gaps after release.
- State FULL (A, B) with flush=1 and in_valid=1 (D) in the same cycle → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; D never appears.
- Continuous stream of 16 instructions with out_ready=1 → 16 outputs in 16 consecutive cycles; occupancy never exceeds 1.
- Assert reset while FULL → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
- Random in_valid/out_ready for 10k cycles against a FIFO scoreboard → no loss, duplication or reorder. Assertions: out_ctrl=0 whenever out_valid=0; in_ready=0 only when occupancy=2.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: payload widths,
// control-field bit positions and the skid-buffer state encoding.
package pipe_pkg;

    localparam int CTRL_W = 7;
    localparam int DATA_W = 69;

    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_ZERO     = 2;
    localparam int CTRL_BRANCH_H = 1;
    localparam int CTRL_BRANCH_L = 0;

    // The encoding doubles as the entry count, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/skid_reg2.sv
// Generic 2-entry skid buffer: main register drives the output, skid register
// catches the one beat in flight when the consumer stalls. Low CLR_W bits are
// the control field, zeroed on reset/flush.
module skid_reg2
    import pipe_pkg::*;
#(
    parameter int W     = 8,
    parameter int CLR_W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    localparam logic [W-1:0] KEEP_MASK = {{(W - CLR_W){1'b1}}, {CLR_W{1'b0}}};

    skid_state_e  state_q, state_d;
    logic [W-1:0] main_q, skid_q;
    logic         accept, take;
    logic         main_load, main_from_skid, skid_load;

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE:     if (accept && !take) state_d = FULL;
                         else if (!accept && take) state_d = EMPTY;
                FULL:    if (take) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready       = (state_q != FULL);
        out_valid      = (state_q != EMPTY);
        occupancy      = state_q;
        main_from_skid = (state_q == FULL);
        main_load      = 1'b0;
        skid_load      = 1'b0;
        unique case (state_q)
            EMPTY:   main_load = accept;
            ONE: begin
                main_load = accept & take;
                skid_load = accept & ~take;
            end
            FULL:    main_load = take;
            default: ;
        endcase
    end

    // NOTE: only the control field is cleared; the data field carries no
    // meaning without out_valid, so it is left unreset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_q <= main_q & KEEP_MASK;
            skid_q <= skid_q & KEEP_MASK;
        end else begin
            if (main_load) main_q <= main_from_skid ? skid_q : in_data;
            if (skid_load) skid_q <= in_data;
        end
    end

    assign out_data = main_q;

endmodule

// File: rtl/exe_mem_stage.sv
// EX->MEM pipeline stage: control and data payloads through a 2-entry skid
// buffer, with bubble zeroing of the control field and flush on branch resolution.
module exe_mem_stage #(
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int DATA_W = pipe_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    import pipe_pkg::*;

    localparam int W = CTRL_W + DATA_W;

    logic [W-1:0] in_pl, out_pl;

    assign in_pl = {in_data, in_ctrl};

    skid_reg2 #(
        .W     (W),
        .CLR_W (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pl),
        .occupancy (occupancy)
    );

    // A bubble must never present a stray RegWrite/MemWrite to MEM.
    assign out_ctrl = out_valid ? out_pl[CTRL_W-1:0] : '0;
    assign out_data = out_pl[W-1:CTRL_W];

endmodule
